// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-decode helpers for the load/store control unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B    = 4'b0001;
   localparam logic [3:0] BE_H    = 4'b0011;
   localparam logic [3:0] BE_W    = 4'b1111;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) || ((f3 == F3_W) && (off != 2'b00));
   endfunction

   // Drop the offset bits that a halfword/word access cannot use.
   function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
      if ((f3 == F3_H) || (f3 == F3_HU)) return {off[1], 1'b0};
      if (f3 == F3_W) return 2'b00;
      return off;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a memory word and sign- or zero-extends it.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata_i[7:0];
      case (off_i)
         2'd1:    byte_v = rdata_i[15:8];
         2'd2:    byte_v = rdata_i[23:16];
         2'd3:    byte_v = rdata_i[31:24];
         default: byte_v = rdata_i[7:0];
      endcase
      half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (funct3_i)
         F3_B:    result_o = {{24{byte_v[7]}}, byte_v};
         F3_BU:   result_o = {24'h0, byte_v};
         F3_H:    result_o = {{16{half_v[15]}}, half_v};
         F3_HU:   result_o = {16'h0, half_v};
         F3_W:    result_o = rdata_i;
         default: result_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control unit: one request at a time, one-cycle memory access, held response.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_we,
   output logic              mem_ld,
   output logic              mem_str,
   input  logic [31:0]       mem_rdata
);

   lsu_state_t        state_q, state_d;
   logic              is_store_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] word_q;
   logic [1:0]        off_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              capture;
   logic              req_legal;
   logic [31:0]       ld_ext;
   logic              unused_addr;

   assign unused_addr = ^req_addr[31:ADDR_W+2];

   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      req_legal = f3_legal(req_is_store, req_funct3) && !misaligned(req_funct3, req_addr[1:0]);
`else
      req_legal = f3_legal(req_is_store, req_funct3);
`endif
   end

   load_extend u_load_extend (
      .rdata_i  (mem_rdata),
      .off_i    (off_q),
      .funct3_i (funct3_q),
      .result_o (ld_ext)
   );

   always_comb begin
      state_d    = state_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      capture    = 1'b0;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      mem_adr    = '0;
      mem_wdata  = 32'h0;
      mem_we     = BE_NONE;
      mem_ld     = 1'b0;
      mem_str    = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               capture = 1'b1;
               if (req_legal) begin
                  state_d = ACCESS;
               end else begin
                  state_d    = RESP;
                  rsp_err_d  = 1'b1;
                  rsp_data_d = 32'h0;
               end
            end
         end
         ACCESS: begin
            mem_adr   = word_q;
            rsp_err_d = 1'b0;
            state_d   = RESP;
            if (is_store_q) begin
               mem_str    = 1'b1;
               rsp_data_d = 32'h0;
               case (funct3_q)
                  F3_B: begin
                     mem_we    = BE_B << off_q;
                     mem_wdata = {4{wdata_q[7:0]}};
                  end
                  F3_H: begin
                     mem_we    = BE_H << {off_q[1], 1'b0};
                     mem_wdata = {2{wdata_q[15:0]}};
                  end
                  F3_W: begin
                     mem_we    = BE_W;
                     mem_wdata = wdata_q;
                  end
                  default: begin
                     mem_we    = BE_NONE;
                     mem_wdata = 32'h0;
                  end
               endcase
            end else begin
               mem_ld     = 1'b1;
               rsp_data_d = ld_ext;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d    = IDLE;
               rsp_data_d = 32'h0;
               rsp_err_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         is_store_q <= 1'b0;
         funct3_q   <= 3'b000;
         word_q     <= '0;
         off_q      <= 2'b00;
         wdata_q    <= 32'h0;
         rsp_data_q <= 32'h0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         if (capture) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            word_q     <= req_addr[ADDR_W+1:2];
            off_q      <= align_off(req_funct3, req_addr[1:0]);
            wdata_q    <= req_wdata;
         end
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected responses, a monitor pops and compares.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [11:0] mem_adr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_we;
   logic        mem_ld;
   logic        mem_str;
   logic [31:0] mem_rdata;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] mem [0:4095];

   lsu_ctrl #(.ADDR_W(12)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .mem_adr      (mem_adr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_ld       (mem_ld),
      .mem_str      (mem_str),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

   always @(posedge clk) begin
      if (mem_str) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) mem[mem_adr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   assign mem_rdata = mem_ld ? mem[mem_adr] : 32'hDEAD_BEEF;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
         end
      end
   end

   task automatic wait_idle(input string nm);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!req_ready && n < 20);
      check({nm, "_idle"}, {31'b0, req_ready}, 32'd1);
   endtask

   // Issues one request and checks its access cycle and response timing.
   task automatic issue(input string nm, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_data,
                        input logic exp_err, input logic [3:0] exp_we, input logic [31:0] exp_wd);
      wait_idle(nm);
      req_valid    = 1'b1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = a;
      req_wdata    = wd;
      exp_q.push_back('{data: exp_data, err: exp_err});
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_is_store = ~st;
      req_funct3   = 3'($urandom());
      req_addr     = $urandom();
      req_wdata    = $urandom();
      @(negedge clk);
      if (exp_err) begin
         check({nm, "_rsp_n1"}, {31'b0, rsp_valid}, 32'd1);
         check({nm, "_no_strobe"}, {30'b0, mem_ld, mem_str}, 32'd0);
      end else begin
         check({nm, "_rsp_n0"}, {31'b0, rsp_valid}, 32'd0);
         check({nm, "_strobe"}, {30'b0, mem_ld, mem_str}, {30'b0, ~st, st});
         check({nm, "_adr"}, {20'b0, mem_adr}, {20'b0, a[13:2]});
         if (st) begin
            check({nm, "_we"}, {28'b0, mem_we}, {28'b0, exp_we});
            check({nm, "_wdata"}, mem_wdata, exp_wd);
         end
         @(negedge clk);
         check({nm, "_rsp_n2"}, {31'b0, rsp_valid}, 32'd1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #12;
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_rsp", {rsp_data[31:1], rsp_data[0] | rsp_valid | rsp_err}, 32'd0);
      check("rst_mem_ctl", {26'b0, mem_we, mem_ld, mem_str}, 32'd0);
      check("rst_mem_data", {mem_wdata[31:12], mem_wdata[11:0] | mem_adr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue("sw10", 1'b1, 3'b010, 32'h10, 32'h8765_43F1, 32'h0, 1'b0, 4'b1111, 32'h8765_43F1);
      issue("lw10a", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8765_43F1, 1'b0, 4'b0, 32'h0);
      issue("sb13", 1'b1, 3'b000, 32'h13, 32'h0000_00AA, 32'h0, 1'b0, 4'b1000, 32'hAAAA_AAAA);
      issue("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hAA65_43F1, 1'b0, 4'b0, 32'h0);
      issue("lb10", 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFF1, 1'b0, 4'b0, 32'h0);
      issue("lbu10", 1'b0, 3'b100, 32'h10, 32'h0, 32'h0000_00F1, 1'b0, 4'b0, 32'h0);
      issue("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_AA65, 1'b0, 4'b0, 32'h0);
      issue("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_AA65, 1'b0, 4'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      issue("lw12", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
`else
      issue("lw12", 1'b0, 3'b010, 32'h12, 32'h0, 32'hAA65_43F1, 1'b0, 4'b0, 32'h0);
`endif
      issue("sh22", 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF);
      issue("sbad", 1'b1, 3'b100, 32'h20, 32'h1111_1111, 32'h0, 1'b1, 4'b0, 32'h0);

      // Illegal load with the response held off for five cycles.
      wait_idle("hold_pre");
      rsp_ready = 1'b0;
      issue("l011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_rsp", {rsp_data[31:2], rsp_data[1:0] | {rsp_valid, rsp_err}}, 32'h3);
         check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;

      // Reset in the middle of a store access: no write, no response.
      wait_idle("rst_sw");
      req_valid    = 1'b1;
      req_is_store = 1'b1;
      req_funct3   = 3'b010;
      req_addr     = 32'h20;
      req_wdata    = 32'h1234_5678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      #2;
      check("rst_sw_str_pre", {31'b0, mem_str}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_sw_str_drop", {27'b0, mem_we, mem_str}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rsp_valid) n++;
      end
      check("rst_sw_no_rsp", n, 32'd0);
      issue("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_0000, 1'b0, 4'b0, 32'h0);

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("sb_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit that sits between the RV32I core's execute stage and the word-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's byte-enable write port and gated read port. Load data comes back sign- or zero-extended, and each request gets exactly one response, with an error flag for illegal accesses.

## Interface
Parameters:
- ADDR_W, 12: memory word-address width; word address = `req_addr[ADDR_W+1:2]`.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: core presents a request.
- `req_ready`, out, 1: unit can accept; high only in IDLE.
- `req_is_store`, in, 1: 1 = store, 0 = load.
- `req_funct3`, in, 3: RV32I width/sign code.
- `req_addr`, in, 32: byte address; bits above ADDR_W+1 are ignored.
- `req_wdata`, in, 32: store data (rs2).
- `rsp_valid`, out, 1: response available; held until accepted.
- `rsp_ready`, in, 1: core accepts response.
- `rsp_data`, out, 32: extended load data; 0 for stores and errors.
- `rsp_err`, out, 1: illegal funct3 or misaligned access.
- `mem_adr`, out, ADDR_W: memory word address.
- `mem_wdata`, out, 32: lane-replicated store data.
- `mem_we`, out, 4: byte write enables.
- `mem_ld`, out, 1: read gate.
- `mem_str`, out, 1: write strobe.
- `mem_rdata`, in, 32: combinational read data, valid while `mem_ld`=1.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, the request registers (is_store, funct3, addr, wdata) are captured.
  - Legal request: go to ACCESS.
  - Illegal request: go to RESP with err=1 and no memory cycle.
- Legal load funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal store funct3: SB 000, SH 001, SW 010. Every other code is illegal in every build.
- ACCESS lasts one cycle.
  - Load: `mem_ld`=1; the extended `mem_rdata` is registered into `rsp_data` at the end of the cycle.
  - Store: `mem_str`=1 with `mem_we` and `mem_wdata` as below.
  - Next state is RESP in both cases.
- Store lanes:
  - SB: we = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: we = 0011 << {addr[1],0}; wdata = {2{wdata[15:0]}}.
  - SW: we = 1111; wdata = wdata.
- Load extract:
  - LB/LBU: byte addr[1:0], sign- or zero-extended to 32 bits.
  - LH/LHU: half addr[1], sign- or zero-extended to 32 bits.
  - LW: full word.
- RESP: `rsp_valid`=1. When `rsp_ready`=1, go to IDLE and clear `rsp_data` and `rsp_err` to 0.
- Outside ACCESS: `mem_ld`, `mem_str`, `mem_we`, `mem_adr` and `mem_wdata` are all 0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, and all `mem_*` outputs 0.
- Request accepted at edge N:
  - ACCESS occupies the cycle between N and N+1.
  - `rsp_valid` rises after edge N+1.
  - Memory write commits at edge N+1.
- Error path: `rsp_valid` rises after edge N with no memory strobe.
- Minimum cadence: 3 cycles per legal request. A new request is accepted only in the IDLE cycle after the RESP handshake, never in the same cycle as `rsp_ready`.
- `rsp_valid`, `rsp_data` and `rsp_err` stay stable while `rsp_ready`=0.
- Reset asserted during ACCESS: `mem_str` and `mem_we` drop immediately, so no write occurs and no response is produced.
- `req_*` inputs may change freely after acceptance; the unit uses only the captured copies.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, give `rsp_err`=1 with no memory cycle.
- Not defined: the misaligned offset is forced to alignment (addr[0] cleared for halfwords, addr[1:0] cleared for words) and the access proceeds normally with `rsp_err`=0.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum `lsu_state_t` {IDLE, ACCESS, RESP};
  - byte-enable constants.
- Sub-module `load_extend`: combinational; inputs rdata, addr[1:0], funct3; output 32-bit extended result.

## Test plan
- SW 0x8765_43F1 to addr 0x10, then LW from 0x10:
  - store cycle shows we=1111, adr=4;
  - load returns 0x8765_43F1, err=0, rsp_valid 2 cycles after acceptance.
- SB 0x0000_00AA to 0x13, then LW from 0x10 → 0xAA65_43F1. Check we=1000 and wdata=0xAAAA_AAAA.
- LB from 0x10 → 0xFFFF_FFF1; LBU from 0x10 → 0x0000_00F1; LH from 0x12 → 0xFFFF_AA65; LHU from 0x12 → 0x0000_AA65.
- LW from 0x12:
  - with `LSU_MISALIGN_TRAP_EN`: err=1, mem_ld never high, rsp one cycle after acceptance;
  - without it: returns the word at 0x10.
- funct3=011 load → err=1, data=0. Hold rsp_ready=0 for 5 cycles: rsp_valid, rsp_data and rsp_err stay stable and req_ready stays 0.
- Assert rst_n low mid-ACCESS of SW 0x1234_5678 to 0x20 → mem_str falls immediately; a later LW from 0x20 returns the old contents.
